mccoy_core: RTL and testbench
=============================

Name: mccoy_core

Overview:
- Parametrised successor to the 8-bit McCoy accumulator processor.
- Data width and register-file depth are configurable.
- Instructions arrive on a valid/ready handshake instead of being sampled every clock; execution uses a two-state fetch/execute FSM.
- New over the original: SUB opcode, zero flag, retire strobe, and separate PC and accumulator outputs in place of a clock-multiplexed pin. It sits behind the chip I/O wrapper, which owns pin muxing.

Parameters:
- DATA_W, 8, width of accumulator, registers, ALU and PC (PC wraps mod 2^DATA_W); legal range 4..16.
- NREGS, 8, number of general registers; power of two, 2..8; register index = low log2(NREGS) bits of the field.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  6  instruction: [2:0] opcode, [5:3] field f.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  core accepts instr this cycle.
- pc_out  output  DATA_W  current PC register.
- acc_out  output  DATA_W  current accumulator.
- zero  output  1  acc_out == 0, combinational from acc.
- retired  output  1  one-cycle pulse: an instruction completed on the previous edge.

Behaviour:
- Reset (synchronous, dominant over everything):
  - pc=0, acc=0, all registers=0, state=FETCH, retired=0.
  - instr_ready=0 in any cycle where reset=1.
- FSM, FETCH:
  - instr_ready=1.
  - If instr_valid=1: latch instr into an internal ir and go to EXEC.
  - Else stay in FETCH.
- FSM, EXEC:
  - instr_ready=0.
  - Execute ir and update pc/acc/registers on the edge leaving EXEC.
  - Return to FETCH; retired=1 in the following cycle.
- Throughput: one instruction per 2 cycles; latency from accept to visible result is 2 edges.
- Operand definitions:
  - imm = sign-extend f to DATA_W (range -4..3).
  - r[f] = register at index f mod NREGS.
- Opcodes (default pc_next = pc+1):
  - 0 LI: acc<=imm.
  - 1 LD: acc<=r[f].
  - 2 ST: r[f]<=acc; acc unchanged.
  - 3 ADD: acc<=acc+r[f].
  - 4 NOT: acc<=~acc; f ignored.
  - 5 BEZ: if acc==0 then pc<=pc+imm, else pc<=pc+1. The branch offset is relative to the BEZ's own pc.
  - 6 JA: pc<=acc.
  - 7 SUB: acc<=acc-r[f].
- Arithmetic:
  - All add/sub is modulo 2^DATA_W, with no carry/borrow output.
  - PC increments and branch targets wrap modulo 2^DATA_W.
- Timing of outputs and registers:
  - pc_out and acc_out change only on the edge leaving EXEC (or on reset).
  - The register file is written only by ST.
  - A LD/ADD/SUB immediately after a ST to the same index sees the new value, because the write completes before the next EXEC.
- Boundary conditions:
  - Reset asserted in EXEC: the latched instruction is discarded, no architectural write, retired stays 0.
  - instr_valid held high across EXEC: ignored (ready=0); the same instr is re-accepted in the next FETCH if still valid.
  - instr_valid low in FETCH: core idles with no state change.

Test Plan:
- Reset held 2 cycles -> pc_out=0x00, acc_out=0x00, zero=1, instr_ready=0 during reset and 1 the cycle after release, retired=0.
- LI f=7 (-1), DATA_W=8 -> after 2 edges acc_out=0xFF, pc_out=0x01, zero=0, retired pulses once.
- LI 3; ST r2; LI 1; ADD r2; SUB r2; SUB r2 -> acc sequence 0x03, 0x03, 0x01, 0x04, 0x01, 0xFE; pc_out=0x06.
- From pc=0 with acc=0: BEZ f=6 (-2) -> pc_out=0xFE (wrap). Then LI 1; BEZ f=6 -> not taken, so LI advances pc 0xFE->0xFF and BEZ advances 0xFF->0x00.
- Handshake: instr_valid pulsed only during EXEC cycles -> never accepted, pc unchanged. valid held high continuously -> instr_ready alternates 1/0 and one instruction is accepted every 2 cycles.
- LI 2 accepted, reset asserted in the EXEC cycle -> acc_out=0, pc_out=0, retired never pulses. Repeat the accept/execute checks with DATA_W=4, NREGS=2: ST f=3 writes r1, and LD f=1 returns the same value.

Source files
------------

// File: rtl/mccoy_core.sv
// mccoy_core: parametrised accumulator processor with valid/ready instruction fetch and two-state fetch/execute FSM
module mccoy_core #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              zero,
    output logic              retired
);
    localparam int IW = $clog2(NREGS);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t            state_q, state_d;
    logic [5:0]        ir_q, ir_d;
    logic [DATA_W-1:0] pc_q, pc_d, acc_q, acc_d, imm, rf;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              retired_q, retired_d;
    logic [2:0]        op, f;
    logic [IW-1:0]     idx;
    always_comb begin
        op        = ir_q[2:0];
        f         = ir_q[5:3];
        idx       = f[IW-1:0];
        imm       = {{(DATA_W-3){f[2]}}, f};
        rf        = regs_q[idx];
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        regs_d    = regs_q;
        retired_d = 1'b0;
        if (state_q == FETCH) begin
            if (instr_valid) begin
                ir_d    = instr;
                state_d = EXEC;
            end
        end else begin
            state_d   = FETCH;
            retired_d = 1'b1;
            pc_d      = pc_q + DATA_W'(1);
            case (op)
                3'd0: acc_d = imm;
                3'd1: acc_d = rf;
                3'd2: regs_d[idx] = acc_q;
                3'd3: acc_d = acc_q + rf;
                3'd4: acc_d = ~acc_q;
                3'd5: pc_d = (acc_q == '0) ? pc_q + imm : pc_q + DATA_W'(1);
                3'd6: pc_d = acc_q;
                default: acc_d = acc_q - rf;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            pc_q      <= '0;
            acc_q     <= '0;
            regs_q    <= '{default: '0};
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            regs_q    <= regs_d;
            retired_q <= retired_d;
        end
    end
    assign instr_ready = (state_q == FETCH) && !reset;
    assign pc_out      = pc_q;
    assign acc_out     = acc_q;
    assign zero        = (acc_q == '0);
    assign retired     = retired_q;
endmodule

// File: tb/tb_mccoy_core.sv
// tb_mccoy_core: directed checks of mccoy_core at 8-bit/8-reg and 4-bit/2-reg configurations
module tb_mccoy_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] instr = '0, instr2 = '0;
    logic       valid = 1'b0, valid2 = 1'b0;
    logic       rdy1, rdy2, z1, z2, ret1, ret2;
    logic [7:0] pc1, acc1;
    logic [3:0] pc2, acc2;
    int         checks = 0, errors = 0;
    logic [7:0] p0;

    always #5 clk = ~clk;

    mccoy_core #(.DATA_W(8), .NREGS(8)) dut1 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(valid),
        .instr_ready(rdy1), .pc_out(pc1), .acc_out(acc1), .zero(z1), .retired(ret1)
    );
    mccoy_core #(.DATA_W(4), .NREGS(2)) dut2 (
        .clk(clk), .reset(reset), .instr(instr2), .instr_valid(valid2),
        .instr_ready(rdy2), .pc_out(pc2), .acc_out(acc2), .zero(z2), .retired(ret2)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic exec(input logic s, input logic [5:0] i);
        @(negedge clk);
        if (s) begin instr2 = i; valid2 = 1'b1; end
        else begin instr = i; valid = 1'b1; end
        @(negedge clk);
        valid = 1'b0;
        valid2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 16'(rdy1), 16'h0);
        chk("rst_pc", 16'(pc1), 16'h00);
        chk("rst_acc", 16'(acc1), 16'h00);
        chk("rst_zero", 16'(z1), 16'h1);
        chk("rst_retired", 16'(ret1), 16'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 16'(rdy1), 16'h1);
        // LI -1
        exec(0, {3'd7, 3'd0});
        chk("li_acc", 16'(acc1), 16'hFF);
        chk("li_pc", 16'(pc1), 16'h01);
        chk("li_zero", 16'(z1), 16'h0);
        chk("li_retired", 16'(ret1), 16'h1);
        @(negedge clk);
        chk("li_retired_once", 16'(ret1), 16'h0);
        // arithmetic sequence
        do_reset();
        exec(0, {3'd3, 3'd0}); chk("seq_li3", 16'(acc1), 16'h03);
        exec(0, {3'd2, 3'd2}); chk("seq_st", 16'(acc1), 16'h03);
        exec(0, {3'd1, 3'd0}); chk("seq_li1", 16'(acc1), 16'h01);
        exec(0, {3'd2, 3'd3}); chk("seq_add", 16'(acc1), 16'h04);
        exec(0, {3'd2, 3'd7}); chk("seq_sub1", 16'(acc1), 16'h01);
        exec(0, {3'd2, 3'd7}); chk("seq_sub2", 16'(acc1), 16'hFE);
        chk("seq_pc", 16'(pc1), 16'h06);
        // branches and wrap
        do_reset();
        exec(0, {3'd6, 3'd5}); chk("bez_taken_pc", 16'(pc1), 16'hFE);
        exec(0, {3'd1, 3'd0}); chk("bez_li_pc", 16'(pc1), 16'hFF);
        exec(0, {3'd6, 3'd5}); chk("bez_not_taken_pc", 16'(pc1), 16'h00);
        exec(0, {3'd0, 3'd4}); chk("not_acc", 16'(acc1), 16'hFE);
        exec(0, {3'd0, 3'd6}); chk("ja_pc", 16'(pc1), 16'hFE);
        exec(0, {3'd5, 3'd2}); chk("st5_pc", 16'(pc1), 16'hFF);
        exec(0, {3'd0, 3'd0}); chk("li0_zero", 16'(z1), 16'h1);
        exec(0, {3'd5, 3'd1}); chk("ld5_acc", 16'(acc1), 16'hFE);
        chk("ld5_pc", 16'(pc1), 16'h01);
        // valid only during EXEC is ignored
        do_reset();
        @(negedge clk);
        instr = {3'd2, 3'd0};
        valid = 1'b1;
        @(negedge clk);
        chk("exec_ready", 16'(rdy1), 16'h0);
        instr = {3'd1, 3'd0};
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec_pulse_pc", 16'(pc1), 16'h01);
        chk("exec_pulse_acc", 16'(acc1), 16'h02);
        // valid held high: one accept every 2 cycles
        p0 = 8'h01;
        @(negedge clk);
        instr = {3'd3, 3'd0};
        valid = 1'b1;
        chk("hold_ready0", 16'(rdy1), 16'h1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ready%0d", i), 16'(rdy1), (i % 2 == 0) ? 16'h1 : 16'h0);
        end
        valid = 1'b0;
        chk("hold_pc", 16'(pc1), 16'(p0 + 8'd3));
        chk("hold_acc", 16'(acc1), 16'h03);
        // reset during EXEC discards the instruction
        do_reset();
        @(negedge clk);
        instr = {3'd2, 3'd0};
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rexec_acc", 16'(acc1), 16'h00);
        chk("rexec_pc", 16'(pc1), 16'h00);
        chk("rexec_retired", 16'(ret1), 16'h0);
        chk("rexec_ready", 16'(rdy1), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rexec_retired2", 16'(ret1), 16'h0);
        chk("rexec_acc2", 16'(acc1), 16'h00);
        // DATA_W=4, NREGS=2
        do_reset();
        exec(1, {3'd7, 3'd0}); chk("n4_li_acc", 16'(acc2), 16'hF);
        chk("n4_li_pc", 16'(pc2), 16'h1);
        chk("n4_li_retired", 16'(ret2), 16'h1);
        exec(1, {3'd3, 3'd2});
        exec(1, {3'd0, 3'd0}); chk("n4_li0_zero", 16'(z2), 16'h1);
        exec(1, {3'd1, 3'd1}); chk("n4_ld_acc", 16'(acc2), 16'hF);
        chk("n4_ld_pc", 16'(pc2), 16'h4);
        exec(1, {3'd1, 3'd0});
        exec(1, {3'd1, 3'd3}); chk("n4_add_wrap", 16'(acc2), 16'h0);
        exec(1, {3'd6, 3'd5}); chk("n4_bez_pc", 16'(pc2), 16'h4);
        exec(1, {3'd1, 3'd7}); chk("n4_sub_acc", 16'(acc2), 16'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
